stream_to_vec: RTL and testbench
================================

# stream_to_vec

Serial-to-parallel front end for the pipelined adder tree. Accepts one WIDTH-bit word per cycle on a valid/ready stream and packs every LANES consecutive words into one LANES-element vector. The vector is presented on a valid/ready output that drives the tree's parallel input array. A collect buffer plus an output register let the next vector fill while the previous one waits, sustaining one word per cycle.

## Interface
- WIDTH, 16, bits per word and per output lane
- LANES, 8, words per output vector; legal values are 2 or greater
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  input word
- in_last  input  1  closes the current vector early (present only with STREAM_TO_VEC_LAST_EN)
- out_valid  output  1  out_data holds a complete vector
- out_ready  input  1  consumer accepts the vector this cycle
- out_data  output  WIDTH x [LANES]  packed vector; lane 0 is the oldest word
- out_count  output  $clog2(LANES+1)  number of valid lanes (present only with STREAM_TO_VEC_LAST_EN)

## Operation
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- A lane counter (0..LANES-1) selects the collect-buffer lane written on each input transfer, then increments.
- States:
  - FILL: in_ready=1.
  - HOLD: the collect buffer is complete but the output register is occupied; in_ready=0.
- The output slot is free when !out_valid || out_ready, evaluated in the same cycle.
- FILL, input transfer on lane LANES-1:
  - Slot free: copy the buffer into out_data, set out_valid, reset the counter to 0, stay in FILL.
  - Slot not free: go to HOLD, with the counter at 0.
- HOLD with slot free: copy the buffer into out_data, set out_valid, go to FILL.
- After an output transfer, out_valid drops unless a new vector loads in the same cycle.
- While out_valid=1, out_data must not change until the output transfer.
- Overflow on the counter cannot occur: it wraps only from LANES-1 to 0.
- Reset (any time, including mid-vector):
  - state=FILL, counter=0, collect buffer cleared, out_data all 0, out_valid=0.
  - in_ready is 0 while rst=0 and 1 from the first cycle after release.
  - Partial vectors are discarded.

## Timing
- Latency: the final word is accepted at edge N; out_valid=1 after edge N, when the slot is free.
- Throughput: one word per cycle and one vector every LANES cycles while out_ready=1.
- Backpressure from out_ready reaches in_ready only after a full collect buffer exists. The maximum words stalled in the block is 2*LANES.
- in_ready is a decode of the registered state only. There is no combinational path from out_ready or in_valid to in_ready.

## Configuration
- STREAM_TO_VEC_LAST_EN defined:
  - in_last and out_count ports exist.
  - An input transfer with in_last=1 on lane k closes the vector as if lane LANES-1 were reached.
  - Lanes k+1..LANES-1 are zero-filled, which is the additive identity, so tree sums stay exact.
  - out_count = k+1.
  - in_last on lane LANES-1 behaves like a normal full vector.
- Undefined: ports are absent and every vector is full.

## Structure
- The package stream_to_vec_pkg holds:
  - state_t enum {FILL, HOLD}
  - the default LANES constant
  - a count-width function returning $clog2(LANES+1)
- Single module; no sub-module. Counter, state register, collect buffer and output register live in one always_ff with async active-low reset.

## Test plan
- Reset release, in_valid=1, data 1..8, out_ready=1 -> out_valid after the 8th edge with out_data[0..7]=1..8; next vector 9..16 follows exactly 8 cycles later.
- out_ready=0 for 20 cycles while streaming -> in_ready drops after 16 accepted words; out_data holds 1..8 stable. Raising out_ready releases 9..16 one cycle after the first handoff.
- Random in_valid and out_ready over 1000 words -> every vector equals 8 consecutive scoreboard words, in order, with none lost or duplicated.
- Assert rst after 5 words of a vector -> out_valid=0 and out_data=0 immediately. After release, the next 8 words form a vector starting with lane 0.
- With STREAM_TO_VEC_LAST_EN: words 7,7,7 with in_last on the 3rd -> out_data={7,7,7,0,0,0,0,0}, out_count=3.
- With STREAM_TO_VEC_LAST_EN: in_last on lane 7 -> out_count=8. A vector closes while HOLD is pending -> it transfers correctly once the slot frees.

Source files
------------

// File: rtl/stream_to_vec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_to_vec_pkg
//  Description : Shared types and constants for the stream_to_vec block.
//                state_t     - collect state (FILL accepts words, HOLD waits
//                              for the output register to free up)
//                c_LANES_DEFAULT / c_WIDTH_DEFAULT - default geometry
//                count_width - width of a lane count able to hold 0..LANES
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_to_vec_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int c_LANES_DEFAULT = 8;
    localparam int c_WIDTH_DEFAULT = 16;

    function automatic int count_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_to_vec_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_to_vec_if
//  Description : Input word stream and output vector stream of stream_to_vec.
//                in_valid/in_ready/in_data  - word stream into the block
//                out_valid/out_ready/out_data - vector stream out of the block
//                in_last/out_count exist only with STREAM_TO_VEC_LAST_EN.
//                modport slave  : the stream_to_vec block
//                modport master : the producer/consumer around it
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_to_vec_if
    import stream_to_vec_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int LANES = c_LANES_DEFAULT
);

    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES-1:0][WIDTH-1:0]   out_data;
`ifdef STREAM_TO_VEC_LAST_EN
    logic                          in_last;
    logic [count_width(LANES)-1:0] out_count;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
`endif

endinterface
`default_nettype wire

// File: rtl/stream_to_vec.sv
`default_nettype none
// ============================================================================
//  Module      : stream_to_vec
//  Description : Serial-to-parallel packer. Collects LANES consecutive
//                WIDTH-bit words into a collect buffer and hands each full
//                vector to an output register (lane 0 = oldest word). The
//                buffer refills while the output register waits, so one
//                word per cycle is sustained.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                bus  - stream_to_vec_if.slave (word in, vector out)
//  Options     : STREAM_TO_VEC_LAST_EN - in_last closes a vector early,
//                remaining lanes are zero-filled, out_count reports lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_to_vec
    import stream_to_vec_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int LANES = c_LANES_DEFAULT
) (
    input  wire logic      clk,
    input  wire logic      rst,
    stream_to_vec_if.slave bus
);

    localparam int              c_LW        = $clog2(LANES);
    localparam int              c_CW        = count_width(LANES);
    localparam logic [c_LW-1:0] c_LANE_LAST = c_LW'(LANES - 1);

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_run;
    logic [c_LW-1:0] r_lane;
    vec_t            r_buf;
    vec_t            r_out;
    logic            r_out_valid;
    vec_t            w_buf_next;
    logic            w_in_xfer;
    logic            w_slot_free;
    logic            w_last;
    logic            w_close;
    logic            w_load_new;
    logic            w_load_held;
`ifdef STREAM_TO_VEC_LAST_EN
    logic [c_CW-1:0] r_buf_count;
    logic [c_CW-1:0] r_out_count;
    logic [c_CW-1:0] w_close_count;
`endif

    // r_run keeps in_ready low until the first edge after reset release;
    // in_ready depends on registered state only.
    assign bus.in_ready  = r_run && (r_state == FILL);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out;
`ifdef STREAM_TO_VEC_LAST_EN
    assign bus.out_count = r_out_count;
    assign w_last        = bus.in_last;
    assign w_close_count = c_CW'(r_lane) + c_CW'(1);
`else
    assign w_last        = 1'b0;
`endif

    always_comb begin
        w_in_xfer    = bus.in_valid && bus.in_ready;
        w_slot_free  = !r_out_valid || bus.out_ready;
        w_close      = w_in_xfer && ((r_lane == c_LANE_LAST) || w_last);
        w_load_new   = (r_state == FILL) && w_close && w_slot_free;
        w_load_held  = (r_state == HOLD) && w_slot_free;

        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_close && !w_slot_free) w_state_next = HOLD;
            HOLD:    if (w_slot_free)             w_state_next = FILL;
            default: w_state_next = FILL;
        endcase

        // Buffer image including the word arriving now. An early close
        // zero-fills the upper lanes so downstream sums are unaffected.
        w_buf_next = r_buf;
        for (int i = 0; i < LANES; i++) begin
            if (i == int'(r_lane)) begin
                w_buf_next[i] = bus.in_data;
            end else if (w_last && (i > int'(r_lane))) begin
                w_buf_next[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FILL;
            r_run       <= 1'b0;
            r_lane      <= '0;
            r_buf       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
`ifdef STREAM_TO_VEC_LAST_EN
            r_buf_count <= '0;
            r_out_count <= '0;
`endif
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_next;

            if (w_in_xfer) begin
                r_buf  <= w_buf_next;
                r_lane <= w_close ? '0 : r_lane + c_LW'(1);
`ifdef STREAM_TO_VEC_LAST_EN
                if (w_close) r_buf_count <= w_close_count;
`endif
            end

            if (w_load_new) begin
                r_out       <= w_buf_next;
                r_out_valid <= 1'b1;
`ifdef STREAM_TO_VEC_LAST_EN
                r_out_count <= w_close_count;
`endif
            end else if (w_load_held) begin
                r_out       <= r_buf;
                r_out_valid <= 1'b1;
`ifdef STREAM_TO_VEC_LAST_EN
                r_out_count <= r_buf_count;
`endif
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_to_vec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_to_vec
//  Description : Self-checking bench for stream_to_vec (WIDTH=16, LANES=8).
//                Stimulus pushes expected vectors into a scoreboard queue;
//                a monitor pops and compares on every output transfer and
//                checks that a stalled vector stays stable.
//                Extra directed cases with STREAM_TO_VEC_LAST_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_to_vec;
    import stream_to_vec_pkg::*;

    localparam int WIDTH = 16;
    localparam int LANES = 8;

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;
    typedef struct packed {
        vec_t       v;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stream_to_vec_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    stream_to_vec #(.WIDTH(WIDTH), .LANES(LANES)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    int   xfer_q[$];
    vec_t acc      = '0;
    int   acc_n    = 0;

    // out_ready: 0 = always 1, 1 = always 0, 2 = random, 3 = manual
    int   rdy_mode = 1;
    logic rdy_rand = 1'b0;
    logic man_rdy  = 1'b0;
    assign bus.out_ready = (rdy_mode == 2) ? rdy_rand :
                           (rdy_mode == 3) ? man_rdy  : (rdy_mode == 0);

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rdy_rand <= 1'($urandom_range(0, 1));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] d, input bit last);
        exp_t e;
        acc[acc_n] = d;
        acc_n++;
        if (acc_n == LANES || last) begin
            e.v   = acc;
            e.cnt = 8'(acc_n);
            exp_q.push_back(e);
            acc   = '0;
            acc_n = 0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [WIDTH-1:0] d, input bit last);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
`ifdef STREAM_TO_VEC_LAST_EN
        bus.in_last  = last;
`endif
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 128'(guard), 128'(0));
        end else begin
            model_accept(d, last);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
`ifdef STREAM_TO_VEC_LAST_EN
        bus.in_last  = 1'b0;
`endif
    endtask

    task automatic drain();
        int g = 0;
        while (g < 300) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) break;
            g++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
        @(negedge clk);
    endtask

    // Monitor: samples just after the falling edge, when inputs are settled.
    vec_t prev_data = '0;
    bit   have_prev = 1'b0;
    bit   prev_xfer = 1'b0;
    always begin : p_mon
        exp_t e;
        @(negedge clk);
        #1;
        if (rst && bus.out_valid) begin
            if (have_prev && !prev_xfer) check("hold_stable", bus.out_data, prev_data);
            if (bus.out_ready) begin
                xfer_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_vector", bus.out_data, 128'(0));
                    if (bus.out_data == '0) begin
                        n_fail++;
                        $display("FAIL unexpected_vector: actual zero vector required none");
                    end
                end else begin
                    e = exp_q.pop_front();
                    check("vector", bus.out_data, e.v);
`ifdef STREAM_TO_VEC_LAST_EN
                    check("out_count", 128'(bus.out_count), 128'(e.cnt));
`endif
                end
            end
            prev_data = bus.out_data;
            have_prev = 1'b1;
            prev_xfer = bus.out_ready;
        end else begin
            have_prev = 1'b0;
        end
    end

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        int k;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
`ifdef STREAM_TO_VEC_LAST_EN
        bus.in_last  = 1'b0;
`endif
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_data",  bus.out_data, 128'(0));
        check("rst_in_ready",  128'(bus.in_ready), 128'(0));
        @(negedge clk);
        rdy_mode = 0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", 128'(bus.in_ready), 128'(1));

        // Full-rate streaming: 1..8 then 9..16
        xfer_q.delete();
        for (int i = 1; i <= 7; i++) send(16'(i), 1'b0);
        check("no_early_valid", 128'(bus.out_valid), 128'(0));
        send(16'd8, 1'b0);
        check("latency_valid", 128'(bus.out_valid), 128'(1));
        for (int i = 9; i <= 16; i++) send(16'(i), 1'b0);
        drain();
        check("vec_spacing", (xfer_q.size() >= 2) ? 128'(xfer_q[1] - xfer_q[0]) : '1, 128'(8));

        // Backpressure: out_ready low for 20 cycles
        man_rdy  = 1'b0;
        rdy_mode = 3;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(k + 1);
            if (bus.in_ready) begin
                model_accept(16'(k + 1), 1'b0);
                k++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", 128'(k), 128'(16));
        check("bp_in_ready", 128'(bus.in_ready), 128'(0));
        xfer_q.delete();
        man_rdy = 1'b1;
        @(negedge clk);
        #2;
        check("bp_handoff_gap", (xfer_q.size() >= 2) ? 128'(xfer_q[1] - xfer_q[0]) : '1, 128'(1));
        @(negedge clk);
        rdy_mode = 0;
        for (int i = 17; i <= 24; i++) send(16'(i), 1'b0);
        drain();

        // Random valid/ready over 1000 words
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            send(16'(i * 37 + 5), 1'b0);
        end
        drain();
        rdy_mode = 0;

        // Reset in the middle of a vector with a vector pending on the output
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send(16'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 5; i++) send(16'(16'h0180 + i), 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 128'(bus.out_valid), 128'(0));
        check("async_rst_data",  bus.out_data, 128'(0));
        exp_q.delete();
        acc   = '0;
        acc_n = 0;
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        @(negedge clk);
        check("rerelease_in_ready", 128'(bus.in_ready), 128'(1));
        for (int i = 0; i < 8; i++) send(16'(16'h0200 + i), 1'b0);
        drain();

`ifdef STREAM_TO_VEC_LAST_EN
        // Early close: {7,7,7,0,0,0,0,0}, count 3
        send(16'd7, 1'b0);
        send(16'd7, 1'b0);
        send(16'd7, 1'b1);
        drain();
        // in_last on lane 7 is a normal full vector
        for (int i = 0; i < 8; i++) send(16'(16'h0300 + i), i == 7);
        drain();
        // Early close while the output register is occupied
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send(16'(16'h0400 + i), 1'b0);
        send(16'h0501, 1'b0);
        send(16'h0502, 1'b0);
        send(16'h0503, 1'b1);
        check("last_hold_in_ready", 128'(bus.in_ready), 128'(0));
        rdy_mode = 0;
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
